mf_phase_selector: RTL and testbench

- Sampling-phase scheduler that sits after the RX matched filters (rrc_filter I/Q).
- Each window, it measures per-phase decision quality of the SPS-oversampled matched-filter output against the 16-QAM grid.
- It picks the best sampling phase and decimates to one symbol per SPS valid samples.
- It asserts a lock flag; downstream slicer/carrier recovery consume sym_I/sym_Q only while locked.

---
 rtl/mf_phase_selector.sv | 216 +++++++++++++++++++++
 tb/tb_mf_phase_selector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mf_phase_selector.sv
// Sampling-phase selector for the oversampled matched-filter output.
// Counts how often each of the SPS phases lands near the 16-QAM grid over a
// window of WIN symbols. It then picks the best phase, with hysteresis once
// locked, and decimates to one symbol per SPS valid samples while locked.
module mf_phase_selector #(
  parameter int DATA_W   = 12,
  parameter int SPS      = 4,
  parameter int LVL_IN   = 648,
  parameter int LVL_OUT  = 1943,
  parameter int TOL      = 350,
  parameter int WIN      = 64,
  parameter int LOCK_CNT = 56,
  parameter int HYST     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   din_I,
  input  logic signed [DATA_W-1:0]   din_Q,
  input  logic                       din_valid,
  output logic signed [DATA_W-1:0]   sym_I,
  output logic signed [DATA_W-1:0]   sym_Q,
  output logic                       sym_valid,
  output logic [$clog2(SPS)-1:0]     best_phase,
  output logic                       locked,
  output logic                       win_done
);

  localparam int PH_W  = $clog2(SPS);
  localparam int SC_W  = $clog2(WIN);
  localparam int CNT_W = $clog2(WIN + 1);
  localparam int DW2   = DATA_W + 2;

  localparam logic signed [DW2-1:0] L_IN   = DW2'(LVL_IN);
  localparam logic signed [DW2-1:0] L_OUT  = DW2'(LVL_OUT);
  localparam logic        [DW2-1:0] TOL_V  = DW2'(TOL);
  localparam logic      [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_CNT);
  localparam logic        [CNT_W:0] HYST_V = (CNT_W+1)'(HYST);

  typedef enum logic [2:0] {
    S_IDLE, S_ACQ, S_EVAL, S_DECIDE, S_TRACK
  } state_t;

  state_t                   r_state, w_state_nx;
  logic [PH_W-1:0]          r_ph;
  logic [SC_W-1:0]          r_sc;
  logic [SPS-1:0][CNT_W-1:0] r_good;
  logic [SPS-1:0][CNT_W-1:0] r_shadow;
  logic [PH_W-1:0]          r_scan;
  logic [CNT_W-1:0]         r_max;
  logic [PH_W-1:0]          r_arg;
  logic [PH_W-1:0]          r_best;
  logic                     r_locked;
  logic                     r_win_done;
  logic signed [DATA_W-1:0] r_sym_I, r_sym_Q;
  logic                     r_sym_valid;

  logic                     w_good, w_step, w_ph_wrap, w_close, w_emit, w_switch;
  logic                     w_scan_last;
  logic [SPS-1:0]           w_inc;
  logic [CNT_W:0]           w_cand, w_incumb;

  function automatic logic [DW2-1:0] f_abs(input logic signed [DW2-1:0] d);
    return d[DW2-1] ? $unsigned(-d) : $unsigned(d);
  endfunction

  // Distance to the nearest grid level; DW2 bits keep |x - lvl| from wrapping.
  function automatic logic [DW2-1:0] f_dist(input logic signed [DATA_W-1:0] x);
    logic signed [DW2-1:0] xe;
    logic        [DW2-1:0] a0, a1, a2, a3, m;
    xe = {{2{x[DATA_W-1]}}, x};
    a0 = f_abs(xe + L_OUT);
    a1 = f_abs(xe + L_IN);
    a2 = f_abs(xe - L_IN);
    a3 = f_abs(xe - L_OUT);
    m  = a0;
    if (a1 < m) m = a1;
    if (a2 < m) m = a2;
    if (a3 < m) m = a3;
    return m;
  endfunction

  assign w_good      = (f_dist(din_I) <= TOL_V) && (f_dist(din_Q) <= TOL_V);
  assign w_step      = (r_state != S_IDLE) && din_valid;
  assign w_ph_wrap   = (r_ph == PH_W'(SPS - 1));
  assign w_close     = w_step && w_ph_wrap && (r_sc == SC_W'(WIN - 1));
  assign w_scan_last = (r_scan == PH_W'(SPS - 1));

  // Challenger must beat the incumbent phase by more than HYST counts.
  assign w_cand   = {1'b0, r_shadow[r_arg]};
  assign w_incumb = {1'b0, r_shadow[r_best]} + HYST_V;
  assign w_switch = (w_cand > w_incumb);

  // Symbols are emitted only from the selected phase while locked.
  assign w_emit = ((r_state == S_TRACK) || (r_state == S_EVAL)) && r_locked &&
                  din_valid && (r_ph == r_best);

  // One-hot increment for the phase of the current good sample
  always_comb begin
    w_inc = '0;
    if (w_good) w_inc[r_ph] = 1'b1;
  end

  // Phase and symbol counters; they advance only on valid samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph <= '0;
      r_sc <= '0;
    end else if (!en) begin
      r_ph <= '0;
      r_sc <= '0;
    end else if (w_step) begin
      r_ph <= w_ph_wrap ? '0 : r_ph + PH_W'(1);
      if (w_ph_wrap) r_sc <= (r_sc == SC_W'(WIN - 1)) ? '0 : r_sc + SC_W'(1);
    end
  end

  // Per-phase good counters; the closing sample lands in the shadow copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good   <= '0;
      r_shadow <= '0;
    end else if (!en) begin
      r_good   <= '0;
      r_shadow <= '0;
    end else if (w_step) begin
      for (int i = 0; i < SPS; i++) begin
        if (w_close) begin
          r_shadow[i] <= r_good[i] + CNT_W'(w_inc[i]);
          r_good[i]   <= '0;
        end else begin
          r_good[i]   <= r_good[i] + CNT_W'(w_inc[i]);
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // FSM next-state; en low always forces IDLE
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   w_state_nx = S_ACQ;
      S_ACQ:    if (w_close) w_state_nx = S_EVAL;
      S_EVAL:   if (w_scan_last) w_state_nx = S_DECIDE;
      S_DECIDE: w_state_nx = S_TRACK;
      S_TRACK:  if (w_close) w_state_nx = S_EVAL;
      default:  w_state_nx = S_IDLE;
    endcase
    if (!en) w_state_nx = S_IDLE;
  end

  // Shadow scan (ties keep the lower phase) and decision apply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan     <= '0;
      r_max      <= '0;
      r_arg      <= '0;
      r_best     <= '0;
      r_locked   <= 1'b0;
      r_win_done <= 1'b0;
    end else if (!en) begin
      r_scan     <= '0;
      r_max      <= '0;
      r_arg      <= '0;
      r_best     <= '0;
      r_locked   <= 1'b0;
      r_win_done <= 1'b0;
    end else begin
      r_win_done <= (r_state == S_EVAL) && w_scan_last;
      if (r_state == S_EVAL) begin
        r_scan <= w_scan_last ? '0 : r_scan + PH_W'(1);
        if ((r_scan == '0) || (r_shadow[r_scan] > r_max)) begin
          r_max <= r_shadow[r_scan];
          r_arg <= r_scan;
        end
      end
      if (r_state == S_DECIDE) begin
        if (!r_locked || w_switch) r_best <= r_arg;
        r_locked <= (r_max >= LOCK_V);
      end
    end
  end

  // Decimated symbol capture; the strobe follows the captured sample by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_I     <= '0;
      r_sym_Q     <= '0;
      r_sym_valid <= 1'b0;
    end else if (!en) begin
      r_sym_I     <= '0;
      r_sym_Q     <= '0;
      r_sym_valid <= 1'b0;
    end else begin
      r_sym_valid <= w_emit;
      if (w_emit) begin
        r_sym_I <= din_I;
        r_sym_Q <= din_Q;
      end
    end
  end

  assign sym_I      = r_sym_I;
  assign sym_Q      = r_sym_Q;
  assign sym_valid  = r_sym_valid;
  assign best_phase = r_best;
  assign locked     = r_locked;
  assign win_done   = r_win_done;

endmodule

// File: tb/tb_mf_phase_selector.sv
// Directed bench for mf_phase_selector: synthetic per-phase good counts per
// window, with decisions, latency, hysteresis, lock loss, en abort and async reset.
module tb_mf_phase_selector;
  localparam int DW  = 12;
  localparam int SPS = 4;
  localparam int WIN = 64;
  localparam int TOL = 350;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 en = 1'b0;
  logic                 din_valid = 1'b0;
  logic signed [DW-1:0] din_I = '0;
  logic signed [DW-1:0] din_Q = '0;
  logic signed [DW-1:0] sym_I, sym_Q;
  logic                 sym_valid, locked, win_done;
  logic [1:0]           best_phase;

  int checks = 0, failures = 0;
  int cyc = 0, nsym = 0, nbad = 0, wd_cnt = 0, last_cyc = 0;
  int n0, b0, w0;

  // good: within TOL of a level on both rails (incl. +-TOL boundaries, rails extremes)
  int gv[8] = '{2047, -648, 1943, -1943, 998, -298, 1593, -2048};
  // bad: TOL+1 from nearest level, or mid-gap
  int bv[8] = '{999, -297, 1592, 0, 1296, -1296, -999, 297};

  mf_phase_selector dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .din_I(din_I), .din_Q(din_Q), .din_valid(din_valid),
    .sym_I(sym_I), .sym_Q(sym_Q), .sym_valid(sym_valid),
    .best_phase(best_phase), .locked(locked), .win_done(win_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int bdist(input int x);
    int m;
    m = absi(x + 1943);
    if (absi(x + 648) < m) m = absi(x + 648);
    if (absi(x - 648) < m) m = absi(x - 648);
    if (absi(x - 1943) < m) m = absi(x - 1943);
    return m;
  endfunction

  always @(negedge clk) begin
    if (sym_valid) begin
      nsym++;
      if (bdist(int'(sym_I)) > TOL || bdist(int'(sym_Q)) > TOL) nbad++;
    end
    if (win_done) wd_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int i, input int q);
    din_I     = i[DW-1:0];
    din_Q     = q[DW-1:0];
    din_valid = 1'b1;
    @(negedge clk);
    last_cyc = cyc;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // Phase p is good for the first g[p] symbols of the window, bad afterwards.
  task automatic run_window(input int g0, input int g1, input int g2, input int g3,
                            input bit gap);
    int g[4];
    g = '{g0, g1, g2, g3};
    for (int s = 0; s < WIN; s++) begin
      for (int p = 0; p < SPS; p++) begin
        if (s < g[p])        send(gv[(s+p)%8], gv[(s+3*p+5)%8]);
        else if (s % 2 == 0) send(bv[(s+p)%8], gv[(s+p)%8]);
        else                 send(gv[(s+p)%8], bv[(s+2*p)%8]);
        if (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // Waits for win_done after the window-close sample, then lets DECIDE apply.
  task automatic wait_dec(input string tag);
    int lat;
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (win_done) begin
        seen = 1'b1;
        lat  = cyc - last_cyc;
      end
    end
    chk({tag, "_latency"}, lat, SPS + 1);
    if (seen) begin
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, int'(win_done), 0);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sym_valid", int'(sym_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_best", int'(best_phase), 0);
    chk("rst_win_done", int'(win_done), 0);
    chk("rst_sym_I", int'(sym_I), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1;

    // A: acquisition, phase 2 dominant
    n0 = nsym;
    run_window(40, 40, 64, 40, 1'b0);
    chk("A_acq_nosym", nsym - n0, 0);
    wait_dec("A");
    chk("A_best", int'(best_phase), 2);
    chk("A_locked", int'(locked), 1);

    // B: tracking, one symbol per SPS samples, all on-grid
    n0 = nsym; b0 = nbad;
    run_window(40, 40, 64, 30, 1'b0);
    chk("B_nsym", nsym - n0, WIN);
    chk("B_nbad", nbad - b0, 0);
    wait_dec("B");
    chk("B_best", int'(best_phase), 2);

    // C/D/E: hysteresis 58 vs 61 holds, 58 vs 64 switches
    run_window(0, 0, 60, 0, 1'b0);
    wait_dec("C");
    chk("C_best", int'(best_phase), 2);
    chk("C_locked", int'(locked), 1);
    run_window(0, 0, 58, 61, 1'b0);
    wait_dec("D");
    chk("D_best_hold", int'(best_phase), 2);
    run_window(0, 0, 58, 64, 1'b0);
    wait_dec("E");
    chk("E_best_switch", int'(best_phase), 3);
    chk("E_locked", int'(locked), 1);

    // G: noisy window, lock lost, phase kept by hysteresis
    run_window(20, 10, 5, 20, 1'b0);
    wait_dec("G");
    chk("G_locked", int'(locked), 0);
    chk("G_best", int'(best_phase), 3);

    // H: unlocked, tie between 1 and 3 goes to 1; no symbols while unlocked
    n0 = nsym;
    run_window(0, 64, 0, 64, 1'b0);
    chk("H_nosym", nsym - n0, 0);
    wait_dec("H");
    chk("H_best_tie", int'(best_phase), 1);
    chk("H_locked", int'(locked), 1);

    // I: en dropped for one cycle during EVAL
    w0 = wd_cnt;
    run_window(64, 0, 0, 0, 1'b0);
    send(0, 0);
    send(0, 0);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("I_locked", int'(locked), 0);
    chk("I_best", int'(best_phase), 0);
    chk("I_sym_valid", int'(sym_valid), 0);
    chk("I_sym_I", int'(sym_I), 0);
    chk("I_win_done", int'(win_done), 0);
    en = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("I_no_win_done", wd_cnt - w0, 0);

    // J: re-acquire with 50% valid duty
    run_window(10, 20, 64, 5, 1'b1);
    wait_dec("J");
    chk("J_best", int'(best_phase), 2);
    chk("J_locked", int'(locked), 1);

    // K: capture a known symbol, then async reset between edges
    send(5, 6);
    send(7, 8);
    send(300, -400);
    send(9, 10);
    chk("K_sym_I", int'(sym_I), 300);
    chk("K_sym_Q", int'(sym_Q), -400);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("K_rst_locked", int'(locked), 0);
    chk("K_rst_best", int'(best_phase), 0);
    chk("K_rst_sym_I", int'(sym_I), 0);
    chk("K_rst_sym_Q", int'(sym_Q), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
